pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter WIDTH, default 32: payload width in bits; legal range 1..256.
REQ-003 Parameter NOP_VALUE, default {WIDTH{1'b0}}: value driven on o_data whenever o_valid=0 (bubble).
REQ-004 Parameter CNT_W, default 16: width of the performance counters; used only when PIPE_BUF_PERF_EN is defined.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 flush  in  1  discard all held and incoming beats.
REQ-008 i_valid  in  1  upstream beat present.
REQ-009 o_ready  out  1  buffer can accept a beat this cycle.
REQ-010 i_data  in  WIDTH  upstream payload.
REQ-011 o_valid  out  1  downstream beat present.
REQ-012 i_ready  in  1  downstream accepts the beat this cycle.
REQ-013 o_data  out  WIDTH  downstream payload.
REQ-014 o_occupancy  out  2  held entries: 0, 1 or 2.
REQ-015 o_stall_cnt  out  CNT_W  stall cycles; present only with PIPE_BUF_PERF_EN.
REQ-016 o_flush_cnt  out  CNT_W  flush events; present only with PIPE_BUF_PERF_EN.

Function
REQ-017 Accept: i_valid && o_ready at a rising edge; Deliver: o_valid && i_ready at a rising edge.
REQ-018 Storage: main register drives o_data; skid register holds a second beat.
REQ-019 FSM states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2); o_occupancy encodes the state directly.
REQ-020 EMPTY: accept -> ONE, main<=i_data; otherwise stay.
REQ-021 ONE: accept only -> FULL, skid<=i_data; deliver only -> EMPTY; accept and deliver -> ONE, main<=i_data; neither -> stay.
REQ-022 FULL: deliver -> ONE, main<=skid; otherwise stay; no accept possible.
REQ-023 o_ready SHALL be 1 in EMPTY and ONE, 0 in FULL and whenever rst=1; no combinational path from i_ready to o_ready.
REQ-024 o_valid SHALL be 1 in ONE and FULL; o_data SHALL equal NOP_VALUE when o_valid=0.
REQ-025 Latency: a beat accepted in EMPTY appears on o_valid/o_data at the next rising edge; beats SHALL be delivered in acceptance order, none dropped or duplicated.
REQ-026 Sustained throughput with i_valid=i_ready=1 SHALL be one beat per cycle.
REQ-027 o_data SHALL stay stable while o_valid=1 and i_ready=0.
REQ-028 flush=1 at an edge SHALL force state EMPTY regardless of i_valid/i_ready; a beat accepted on that edge is discarded.
REQ-029 A beat delivered (o_valid && i_ready) on a flush edge counts as consumed downstream.
REQ-030 flush SHALL NOT gate o_ready combinationally.

Reset
REQ-031 rst=1 at an edge SHALL force state EMPTY, o_valid=0, o_data=NOP_VALUE, o_occupancy=0, and both counters to 0.
REQ-032 rst SHALL override flush and any handshake on the same edge; held beats are lost.
REQ-033 o_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-034 Macro PIPE_BUF_PERF_EN defined: o_stall_cnt increments every edge with o_valid=1 and i_ready=0; o_flush_cnt increments every flush edge with occupancy>0 or a beat accepted; both saturate at all-ones, never wrap.
REQ-035 Macro PIPE_BUF_PERF_EN undefined: counter ports, registers and logic absent; all other behaviour identical.

Verification
REQ-036 Reset then i_valid=1, i_data=0x0000_00A5, i_ready=1 -> next cycle o_valid=1, o_data=0x0000_00A5, o_occupancy=1.
REQ-037 i_ready=0, push 0x11, 0x22 -> o_occupancy=2, o_ready=0, o_data=0x11; then i_ready=1 -> outputs 0x11, 0x22 on consecutive cycles, then o_valid=0, o_data=NOP_VALUE.
REQ-038 Stream 0x1..0x8 with i_valid=i_ready=1 -> 8 consecutive delivered beats 0x1..0x8, no gaps, o_occupancy stays 1.
REQ-039 FULL with 0x33, 0x44; flush=1 with i_valid=1, i_data=0x55 -> next cycle o_valid=0, o_occupancy=0, 0x55 never delivered; flush counter +1.
REQ-040 PERF_EN, CNT_W=4, o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt reaches 0xF and holds.
REQ-041 rst=1 together with flush=1 in state FULL -> next cycle o_valid=0, counters 0, o_ready=1 once rst=0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid-buffered pipeline stage with registered ready
// Optional stall/flush performance counters are built when PIPE_BUF_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occupancy
`ifdef PIPE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } bufState;

  bufState          state, stateNext;
  logic [WIDTH-1:0] mainQ, skidQ;
  logic             mainLoad, mainFromSkid, skidLoad;
  logic             accept, deliver;

  // Ready depends only on registered state (and reset), never on i_ready or flush.
  assign o_ready     = (state != FULL) && !rst;
  assign o_valid     = (state != EMPTY);
  assign o_data      = o_valid ? mainQ : NOP_VALUE;
  assign o_occupancy = state;

  assign accept  = i_valid && o_ready;
  assign deliver = o_valid && i_ready;

  always_comb begin
    stateNext    = state;
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = ONE;
          mainLoad  = 1'b1;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          stateNext = FULL;
          skidLoad  = 1'b1;
        end else if (!accept && deliver) begin
          stateNext = EMPTY;
        end else if (accept && deliver) begin
          mainLoad = 1'b1;
        end
      end
      FULL: begin
        if (deliver) begin
          stateNext    = ONE;
          mainLoad     = 1'b1;
          mainFromSkid = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Data registers may still load on a flush edge; EMPTY hides them behind NOP_VALUE.
    if (flush) stateNext = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      mainQ <= '0;
      skidQ <= '0;
    end else begin
      state <= stateNext;
      if (mainLoad) mainQ <= mainFromSkid ? skidQ : i_data;
      if (skidLoad) skidQ <= i_data;
    end
  end

`ifdef PIPE_BUF_PERF_EN
  logic stallEvt, flushEvt;

  assign stallEvt = o_valid && !i_ready;
  assign flushEvt = flush && (o_valid || accept);

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (stallEvt && (o_stall_cnt != {CNT_W{1'b1}}))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (flushEvt && (o_flush_cnt != {CNT_W{1'b1}}))
        o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unusedCnt;
  assign unusedCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf
// Counter checks are compiled in when PIPE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;
  localparam int           W     = 32;
  localparam int           CNT_W = 4;
  localparam logic [W-1:0] NOP   = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst, flush, i_valid, i_ready;
  logic [W-1:0] i_data;
  logic         o_ready, o_valid;
  logic [W-1:0] o_data;
  logic [1:0]   o_occupancy;
`ifdef PIPE_BUF_PERF_EN
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
`endif

  logic [W-1:0]     sbq[$];
  logic [CNT_W-1:0] stallExp = '0;
  logic [CNT_W-1:0] flushExp = '0;
  int               vectors = 0;
  int               miscompares = 0;

  pipe_stage_buf #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_occupancy(o_occupancy)
`ifdef PIPE_BUF_PERF_EN
    , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one edge and updates the scoreboard for it; returns at posedge+1.
  task automatic apply(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input logic rs);
    logic acc, hasBeat;
    i_valid = v; i_data = d; i_ready = r; flush = f; rst = rs;
    hasBeat = (sbq.size() > 0);
    acc     = v && (sbq.size() < 2);
    if (rs) begin
      sbq.delete();
      stallExp = '0;
      flushExp = '0;
    end else begin
      if (hasBeat && !r && stallExp != {CNT_W{1'b1}}) stallExp = stallExp + 1'b1;
      if (f && (hasBeat || acc) && flushExp != {CNT_W{1'b1}}) flushExp = flushExp + 1'b1;
      if (hasBeat && r) void'(sbq.pop_front());
      if (f) sbq.delete();
      else if (acc) sbq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 32'h78, 1'b0, 1'b0, 1'b1);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    vectors++; if (o_data !== NOP) begin miscompares++; $display("FAIL reset_data: got %h expected %h", o_data, NOP); end
    vectors++; if (o_occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", o_occupancy); end
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst: got %b expected 0", o_ready); end
`ifdef PIPE_BUF_PERF_EN
    vectors++; if (o_stall_cnt !== '0 || o_flush_cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %h/%h expected 0/0", o_stall_cnt, o_flush_cnt); end
`endif
    i_valid = 1'b0; flush = 1'b0; i_ready = 1'b0; rst = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b expected 1", o_ready); end
  endtask

  task automatic test_single();
    apply(1'b1, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", o_valid); end
    vectors++; if (o_data !== 32'h0000_00A5) begin miscompares++; $display("FAIL single_data: got %h expected 000000a5", o_data); end
    vectors++; if (o_occupancy !== 2'd1) begin miscompares++; $display("FAIL single_occ: got %0d expected 1", o_occupancy); end
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++; if (o_valid !== 1'b0 || o_data !== NOP) begin miscompares++; $display("FAIL single_drain: got %b/%h expected 0/%h", o_valid, o_data, NOP); end
  endtask

  task automatic test_skid();
    logic [W-1:0] expSeq[2];
    expSeq[0] = 32'h11;
    expSeq[1] = 32'h22;
    apply(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    vectors++; if (o_occupancy !== 2'd2) begin miscompares++; $display("FAIL skid_occ: got %0d expected 2", o_occupancy); end
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready: got %b expected 0", o_ready); end
    vectors++; if (o_data !== 32'h11) begin miscompares++; $display("FAIL skid_head: got %h expected 00000011", o_data); end
    apply(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    vectors++; if (o_data !== 32'h11 || o_occupancy !== 2'd2) begin miscompares++; $display("FAIL skid_hold: got %h/%0d expected 00000011/2", o_data, o_occupancy); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (o_valid !== 1'b1 || o_data !== expSeq[k]) begin miscompares++; $display("FAIL skid_out%0d: got %b/%h expected 1/%h", k, o_valid, o_data, expSeq[k]); end
      apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    vectors++; if (o_valid !== 1'b0 || o_data !== NOP || o_occupancy !== 2'd0) begin miscompares++; $display("FAIL skid_empty: got %b/%h/%0d expected 0/%h/0", o_valid, o_data, o_occupancy, NOP); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      apply(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      vectors++; if (o_valid !== 1'b1 || o_data !== W'(i)) begin miscompares++; $display("FAIL stream_beat%0d: got %b/%h expected 1/%h", i, o_valid, o_data, W'(i)); end
      vectors++; if (o_occupancy !== 2'd1 || o_ready !== 1'b1) begin miscompares++; $display("FAIL stream_occ%0d: got %0d/%b expected 1/1", i, o_occupancy, o_ready); end
    end
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_flush();
    apply(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    vectors++; if (o_occupancy !== 2'd2) begin miscompares++; $display("FAIL flush_fill: got %0d expected 2", o_occupancy); end
    apply(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    vectors++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_full: got %b/%0d expected 0/0", o_valid, o_occupancy); end
    vectors++; if (o_ready !== 1'b1 || o_data !== NOP) begin miscompares++; $display("FAIL flush_outs: got %b/%h expected 1/%h", o_ready, o_data, NOP); end
`ifdef PIPE_BUF_PERF_EN
    vectors++; if (o_flush_cnt !== flushExp) begin miscompares++; $display("FAIL flush_cnt_full: got %0d expected %0d", o_flush_cnt, flushExp); end
`endif
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost%0d: got %b/%h expected 0", k, o_valid, o_data); end
    end
    apply(1'b0, '0, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_BUF_PERF_EN
    vectors++; if (o_flush_cnt !== flushExp) begin miscompares++; $display("FAIL flush_cnt_idle: got %0d expected %0d", o_flush_cnt, flushExp); end
`endif
    apply(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    vectors++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_one: got %b/%0d expected 0/0", o_valid, o_occupancy); end
`ifdef PIPE_BUF_PERF_EN
    vectors++; if (o_flush_cnt !== flushExp) begin miscompares++; $display("FAIL flush_cnt_one: got %0d expected %0d", o_flush_cnt, flushExp); end
`endif
  endtask

  task automatic test_stall_sat();
`ifdef PIPE_BUF_PERF_EN
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    apply(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (k == 14) begin
        vectors++; if (o_stall_cnt !== 4'd14) begin miscompares++; $display("FAIL stall_cnt14: got %0d expected 14", o_stall_cnt); end
      end
    end
    vectors++; if (o_stall_cnt !== 4'hF) begin miscompares++; $display("FAIL stall_sat: got %h expected f", o_stall_cnt); end
    vectors++; if (o_data !== 32'h66) begin miscompares++; $display("FAIL stall_stable: got %h expected 00000066", o_data); end
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_flush();
    apply(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'hAA, 1'b1, 1'b1, 1'b1);
    vectors++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin miscompares++; $display("FAIL rstflush_state: got %b/%0d expected 0/0", o_valid, o_occupancy); end
`ifdef PIPE_BUF_PERF_EN
    vectors++; if (o_stall_cnt !== '0 || o_flush_cnt !== '0) begin miscompares++; $display("FAIL rstflush_cnt: got %h/%h expected 0/0", o_stall_cnt, o_flush_cnt); end
`endif
    rst = 1'b0; flush = 1'b0; i_valid = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rstflush_ready: got %b expected 1", o_ready); end
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rstflush_lost: got %b/%h expected 0", o_valid, o_data); end
  endtask

  task automatic test_random();
    logic [W-1:0] expD;
    for (int n = 0; n < 300; n++) begin
      apply(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'b0);
      expD = (sbq.size() > 0) ? sbq[0] : NOP;
      vectors++; if (o_occupancy !== 2'(sbq.size())) begin miscompares++; $display("FAIL rand_occ@%0d: got %0d expected %0d", n, o_occupancy, sbq.size()); end
      vectors++; if (o_valid !== (sbq.size() > 0) || o_data !== expD) begin miscompares++; $display("FAIL rand_data@%0d: got %b/%h expected %b/%h", n, o_valid, o_data, sbq.size() > 0, expD); end
      vectors++; if (o_ready !== (sbq.size() < 2)) begin miscompares++; $display("FAIL rand_ready@%0d: got %b expected %b", n, o_ready, sbq.size() < 2); end
`ifdef PIPE_BUF_PERF_EN
      vectors++; if (o_stall_cnt !== stallExp || o_flush_cnt !== flushExp) begin miscompares++; $display("FAIL rand_cnt@%0d: got %0d/%0d expected %0d/%0d", n, o_stall_cnt, o_flush_cnt, stallExp, flushExp); end
`endif
    end
  endtask

  initial begin
    i_valid = 1'b0; i_data = '0; i_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    test_reset();
    test_single();
    test_skid();
    test_stream();
    test_flush();
    test_stall_sat();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
